// File: rtl/aer_pkg.sv
// Shared types and constants for the AER transmit arbiter: handshake FSM
// states, default sizing and a constant-evaluable log2 helper.
package aer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } aer_state_t;

    localparam int N_SRC_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/aer_rr_select.sv
// Combinational round-robin picker: first set pending bit at or after rr_ptr_i,
// wrapping modulo N_SRC.
module aer_rr_select
    import aer_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int ADDR_W = clog2(N_SRC)
) (
    input  logic [N_SRC-1:0]  pending_i,
    input  logic [ADDR_W-1:0] rr_ptr_i,
    output logic [ADDR_W-1:0] grant_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] cand_idx [N_SRC];
    logic [N_SRC-1:0]  hit;

    // cand_idx[k] is the source visited k steps after the pointer.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
            logic [ADDR_W:0] sum;
            assign sum          = {1'b0, rr_ptr_i} + (ADDR_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (ADDR_W+1)'(N_SRC))
                                ? ADDR_W'(sum - (ADDR_W+1)'(N_SRC))
                                : sum[ADDR_W-1:0];
            assign hit[gi]      = pending_i[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant_o = cand_idx[i];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aer_tx_arbiter.sv
// Shares one AER bus among N_SRC spike sources: latches events, grants them
// round-robin and runs a 4-phase req/ack handshake per grant.
module aer_tx_arbiter
    import aer_pkg::*;
#(
    parameter int N_SRC       = N_SRC_DEF,
    parameter int ADDR_W      = clog2(N_SRC),
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_SRC-1:0]  ev_in,
    input  logic              ack,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [N_SRC-1:0]  pending,
    output logic              overflow,
    input  logic              clr_ovf
);

    aer_state_t        state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic              ack_s;
    logic [N_SRC-1:0]  pending_q, pending_d, clr;
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d, addr_q, addr_d, grant_idx;
    logic              grant_valid, grant, req_q, overflow_q, overflow_d, ovf_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ack_sync_q <= '0;
        else       ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
    end
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    aer_rr_select #(
        .N_SRC  (N_SRC),
        .ADDR_W (ADDR_W)
    ) u_rr_select (
        .pending_i (pending_q),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (grant_idx),
        .valid_o   (grant_valid)
    );

    assign grant = (state_q == IDLE) && enable && grant_valid;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_clr
            assign clr[gi] = grant && (grant_idx == ADDR_W'(gi));
        end
    endgenerate

    // A new event on the granted source survives its own clear.
    assign pending_d  = (pending_q & ~clr) | ev_in;
    assign ovf_hit    = |(ev_in & pending_q & ~clr);
    assign overflow_d = ovf_hit | (overflow_q & ~clr_ovf);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = SETUP;
                    addr_d   = grant_idx;
                    rr_ptr_d = (grant_idx == ADDR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            SETUP:   state_d = REQ;
            REQ:     if (ack_s)  state_d = REL;
            REL:     if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d == REQ);
            addr_q     <= addr_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign req      = req_q;
    assign addr     = addr_q;
    assign busy     = (state_q != IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule
